// File: rtl/core_sequencer.sv
// Multi-cycle control sequencer: owns PC and IR and walks each instruction through
// FETCH, DECODE, EXEC or MEM, plus HALT/resume. Optional retire counter: SEQ_RETIRE_CNT_EN.
module core_sequencer #(
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [31:0]     instr_in,
    input  logic            imem_ready,
    input  logic            ldst,
    input  logic            snl,
    input  logic            halt,
    input  logic            en,
    input  logic            branch,
    input  logic            to_pc,
    input  logic            write_enable,
    input  logic            set_flags,
    input  logic            cond_true,
    input  logic [PC_W-1:0] branch_target,
    input  logic            dmem_ready,
    input  logic            resume,
    output logic [PC_W-1:0] pc,
    output logic [31:0]     ir,
    output logic            imem_req,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic            rf_we,
    output logic            flags_we,
    output logic            halted,
    output logic [2:0]      state,
    output logic [31:0]     retired
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pc_next;
    logic [PC_W-1:0] w_pc_inc;
    logic [31:0]     r_ir;
    logic            w_ir_load;
    logic            w_imem_req;
    logic            w_dmem_req;
    logic            w_dmem_we;
    logic            w_rf_we;
    logic            w_flags_we;
    logic            w_halted;

    assign w_pc_inc = r_pc + {{(PC_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_PC;
            r_ir    <= '0;
        end else begin
            r_state <= w_next;
            r_pc    <= w_pc_next;
            if (w_ir_load) begin
                r_ir <= instr_in;
            end
        end
    end

    always_comb begin
        w_next     = r_state;
        w_pc_next  = r_pc;
        w_ir_load  = 1'b0;
        w_imem_req = 1'b0;
        w_dmem_req = 1'b0;
        w_dmem_we  = 1'b0;
        w_rf_we    = 1'b0;
        w_flags_we = 1'b0;
        w_halted   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_next = S_FETCH;
            end
            S_FETCH: begin
                w_imem_req = 1'b1;
                if (imem_ready) begin
                    w_ir_load = 1'b1;
                    w_next    = S_DECODE;
                end
            end
            S_DECODE: begin
                if (halt) begin
                    w_next = S_HALT;
                end else if (ldst) begin
                    w_next = S_MEM;
                end else begin
                    w_next = S_EXEC;
                end
            end
            S_EXEC: begin
                w_rf_we    = write_enable & en;
                w_flags_we = set_flags & en;
                w_pc_next  = (to_pc | (branch & cond_true)) ? branch_target : w_pc_inc;
                w_next     = S_FETCH;
            end
            S_MEM: begin
                // Request strobes stay up through wait cycles; the load writeback
                // lands in the completing cycle.
                w_dmem_req = 1'b1;
                w_dmem_we  = snl;
                if (dmem_ready) begin
                    w_rf_we   = ~snl;
                    w_pc_next = w_pc_inc;
                    w_next    = S_FETCH;
                end
            end
            S_HALT: begin
                w_halted = 1'b1;
                if (resume) begin
                    w_pc_next = w_pc_inc;
                    w_next    = S_FETCH;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Gating with rst_n keeps every strobe low in the reset cycle itself.
    assign imem_req = rst_n & w_imem_req;
    assign dmem_req = rst_n & w_dmem_req;
    assign dmem_we  = rst_n & w_dmem_we;
    assign rf_we    = rst_n & w_rf_we;
    assign flags_we = rst_n & w_flags_we;
    assign halted   = rst_n & w_halted;

    assign pc    = r_pc;
    assign ir    = r_ir;
    assign state = r_state;

`ifdef SEQ_RETIRE_CNT_EN
    logic [31:0] r_retired;
    logic        w_retire;

    assign w_retire = (r_state == S_EXEC) | ((r_state == S_MEM) & dmem_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_retired <= '0;
        end else if (w_retire) begin
            r_retired <= r_retired + 32'd1;
        end
    end

    assign retired = r_retired;
`else
    assign retired = '0;
`endif

endmodule

// File: tb/tb_core_sequencer.sv
// Self-checking bench for core_sequencer: directed instruction table, random program
// against a rule-level model, and hand-written reset sequences.
module tb_core_sequencer;
    localparam int K_ALU  = 0;
    localparam int K_LD   = 1;
    localparam int K_ST   = 2;
    localparam int K_HALT = 3;
`ifdef SEQ_RETIRE_CNT_EN
    localparam bit RET_ON = 1'b1;
`else
    localparam bit RET_ON = 1'b0;
`endif

    typedef struct {
        int          kind;
        int          fw;
        int          mw;
        logic        we, en, sf, br, ct, tp;
        logic [15:0] tgt;
        logic [31:0] word;
        logic [15:0] exp_pc;
        logic [31:0] exp_ret;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr_in;
    logic        imem_ready, ldst, snl, halt, en, branch, to_pc;
    logic        write_enable, set_flags, cond_true;
    logic [15:0] branch_target;
    logic        dmem_ready, resume;
    logic [15:0] pc;
    logic [31:0] ir;
    logic        imem_req, dmem_req, dmem_we, rf_we, flags_we, halted;
    logic [2:0]  state;
    logic [31:0] retired;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    core_sequencer #(.PC_W(16), .RESET_PC(16'h0010)) dut (
        .clk(clk), .rst_n(rst_n), .instr_in(instr_in), .imem_ready(imem_ready),
        .ldst(ldst), .snl(snl), .halt(halt), .en(en), .branch(branch), .to_pc(to_pc),
        .write_enable(write_enable), .set_flags(set_flags), .cond_true(cond_true),
        .branch_target(branch_target), .dmem_ready(dmem_ready), .resume(resume),
        .pc(pc), .ir(ir), .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .rf_we(rf_we), .flags_we(flags_we), .halted(halted), .state(state), .retired(retired)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_cycle(input string nm, input logic [2:0] st, input logic ireq,
                             input logic dreq, input logic dwe, input logic rfw,
                             input logic flw, input logic hlt);
        logic [8:0] a;
        logic [8:0] e;
        a = {state, imem_req, dmem_req, dmem_we, rf_we, flags_we, halted};
        e = {st, ireq, dreq, dwe, rfw, flw, hlt};
        chk(nm, {23'd0, a}, {23'd0, e});
    endtask

    task automatic rand_all();
        instr_in      = $urandom;
        imem_ready    = 1'($urandom_range(0, 1));
        ldst          = 1'($urandom_range(0, 1));
        snl           = 1'($urandom_range(0, 1));
        halt          = 1'($urandom_range(0, 1));
        en            = 1'($urandom_range(0, 1));
        branch        = 1'($urandom_range(0, 1));
        to_pc         = 1'($urandom_range(0, 1));
        write_enable  = 1'($urandom_range(0, 1));
        set_flags     = 1'($urandom_range(0, 1));
        cond_true     = 1'($urandom_range(0, 1));
        branch_target = 16'($urandom);
        dmem_ready    = 1'($urandom_range(0, 1));
        resume        = 1'($urandom_range(0, 1));
    endtask

    task automatic drive_dec(input vec_t v);
        halt = (v.kind == K_HALT);
        if (v.kind != K_HALT) ldst = (v.kind == K_LD) || (v.kind == K_ST);
        if (v.kind == K_LD || v.kind == K_ST) snl = (v.kind == K_ST);
        write_enable  = v.we;
        en            = v.en;
        set_flags     = v.sf;
        branch        = v.br;
        cond_true     = v.ct;
        to_pc         = v.tp;
        branch_target = v.tgt;
    endtask

    // Runs one instruction from the first FETCH cycle; leaves the DUT just past
    // the edge into the next FETCH.
    task automatic do_instr(input vec_t v, input logic [15:0] start_pc,
                            input logic [15:0] exp_pc, input logic [31:0] exp_ret);
        logic is_st;
        is_st = (v.kind == K_ST);
        for (int k = 0; k <= v.fw; k++) begin
            @(negedge clk);
            rand_all();
            imem_ready = (k == v.fw);
            if (k == v.fw) instr_in = v.word;
            #1 chk_cycle("fetch", 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            chk("fetch_pc", {16'd0, pc}, {16'd0, start_pc});
        end
        @(negedge clk);
        rand_all();
        drive_dec(v);
        #1 chk_cycle("decode", 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("ir", ir, v.word);
        if (v.kind == K_ALU) begin
            @(negedge clk);
            rand_all();
            drive_dec(v);
            #1 chk_cycle("exec", 3'd3, 1'b0, 1'b0, 1'b0, v.we & v.en, v.sf & v.en, 1'b0);
        end else if (v.kind == K_HALT) begin
            for (int k = 0; k <= v.mw; k++) begin
                @(negedge clk);
                rand_all();
                resume = (k == v.mw);
                #1 chk_cycle("halt", 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
                chk("halt_pc", {16'd0, pc}, {16'd0, start_pc});
            end
        end else begin
            for (int k = 0; k <= v.mw; k++) begin
                @(negedge clk);
                rand_all();
                drive_dec(v);
                dmem_ready = (k == v.mw);
                #1 chk_cycle("mem", 3'd4, 1'b0, 1'b1, is_st, (k == v.mw) && !is_st, 1'b0, 1'b0);
            end
        end
        @(posedge clk);
        #1;
        chk("pc_after", {16'd0, pc}, {16'd0, exp_pc});
        chk("state_after", {29'd0, state}, 32'd1);
        chk("retired", retired, exp_ret);
    endtask

    function automatic vec_t mk(input int kind, input int fw, input int mw,
                                input logic we, input logic en_i, input logic sf,
                                input logic br, input logic ct, input logic tp,
                                input logic [15:0] tgt, input logic [15:0] epc,
                                input int nret);
        vec_t v;
        v.kind = kind; v.fw = fw; v.mw = mw;
        v.we = we; v.en = en_i; v.sf = sf; v.br = br; v.ct = ct; v.tp = tp;
        v.tgt = tgt; v.word = $urandom; v.exp_pc = epc;
        v.exp_ret = RET_ON ? 32'(nret) : 32'd0;
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t        tbl[12];
        vec_t        v;
        logic [15:0] cur;
        logic [15:0] m_pc;
        logic [15:0] nxt;
        logic [31:0] m_ret;

        tbl[0]  = mk(K_ALU,  0, 0, 1, 1, 0, 0, 0, 0, 16'h0000, 16'h0011, 1);
        tbl[1]  = mk(K_ALU,  1, 0, 1, 0, 1, 0, 0, 0, 16'h0000, 16'h0012, 2);
        tbl[2]  = mk(K_ALU,  0, 0, 1, 1, 1, 0, 0, 0, 16'h0000, 16'h0013, 3);
        tbl[3]  = mk(K_LD,   0, 2, 1, 1, 1, 0, 0, 0, 16'h0000, 16'h0014, 4);
        tbl[4]  = mk(K_ST,   2, 1, 1, 1, 1, 1, 1, 1, 16'h0999, 16'h0015, 5);
        tbl[5]  = mk(K_ALU,  0, 0, 0, 1, 0, 1, 1, 0, 16'h0100, 16'h0100, 6);
        tbl[6]  = mk(K_ALU,  0, 0, 0, 1, 0, 1, 0, 0, 16'h0200, 16'h0101, 7);
        tbl[7]  = mk(K_ALU,  0, 0, 0, 1, 0, 0, 0, 1, 16'hFFFF, 16'hFFFF, 8);
        tbl[8]  = mk(K_ALU,  0, 0, 1, 1, 0, 0, 1, 0, 16'h1234, 16'h0000, 9);
        tbl[9]  = mk(K_ALU,  0, 0, 0, 1, 0, 1, 1, 1, 16'h0042, 16'h0042, 10);
        tbl[10] = mk(K_HALT, 0, 3, 1, 1, 1, 1, 1, 1, 16'h0777, 16'h0043, 10);
        tbl[11] = mk(K_ST,   0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0044, 11);

        // Reset state with random inputs toggling.
        rst_n = 1'b0;
        rand_all();
        repeat (2) @(negedge clk);
        rand_all();
        #1 chk_cycle("reset_out", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset_pc", {16'd0, pc}, 32'h0010);
        chk("reset_ir", ir, 32'd0);
        chk("reset_ret", retired, 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        rand_all();
        #1 chk_cycle("idle", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        cur = 16'h0010;
        for (int i = 0; i < 12; i++) begin
            do_instr(tbl[i], cur, tbl[i].exp_pc, tbl[i].exp_ret);
            cur = tbl[i].exp_pc;
        end

        // Random program against the rule-level model.
        m_pc  = cur;
        m_ret = RET_ON ? 32'd11 : 32'd0;
        for (int n = 0; n < 150; n++) begin
            v.kind = $urandom_range(0, 3);
            v.fw   = $urandom_range(0, 2);
            v.mw   = $urandom_range(0, 3);
            v.we   = 1'($urandom_range(0, 1));
            v.en   = 1'($urandom_range(0, 1));
            v.sf   = 1'($urandom_range(0, 1));
            v.br   = 1'($urandom_range(0, 1));
            v.ct   = 1'($urandom_range(0, 1));
            v.tp   = 1'($urandom_range(0, 1));
            v.tgt  = (n % 10 == 0) ? 16'hFFFF : 16'($urandom);
            v.word = $urandom;
            if (v.kind == K_ALU && (v.tp || (v.br && v.ct))) nxt = v.tgt;
            else nxt = m_pc + 16'd1;
            if (RET_ON && v.kind != K_HALT) m_ret = m_ret + 32'd1;
            do_instr(v, m_pc, nxt, m_ret);
            m_pc = nxt;
        end

        // Reset asserted in the middle of a store's MEM wait.
        @(negedge clk);
        rand_all();
        imem_ready = 1'b1;
        @(negedge clk);
        rand_all();
        halt = 1'b0; ldst = 1'b1; snl = 1'b1;
        @(negedge clk);
        rand_all();
        halt = 1'b0; ldst = 1'b1; snl = 1'b1; dmem_ready = 1'b0;
        #1 chk_cycle("mem_before_rst", 3'd4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        #1 rst_n = 1'b0;
        snl = 1'b0; dmem_ready = 1'b1; write_enable = 1'b1; en = 1'b1; set_flags = 1'b1;
        #1 chk_cycle("mem_rst_drop", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("mem_rst_pc", {16'd0, pc}, 32'h0010);
        chk("mem_rst_ret", retired, 32'd0);
        chk("mem_rst_ir", ir, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rand_all();
        #1 chk_cycle("idle2", 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        v = mk(K_ALU, 0, 0, 1, 1, 1, 0, 0, 0, 16'h0000, 16'h0011, 1);
        do_instr(v, 16'h0010, 16'h0011, v.exp_ret);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
